signed_non_restoring_divider: RTL

- Iterative non-restoring integer divider, one quotient bit per cycle.
- Supports signed (two's complement) and unsigned operands, selected per operation.
- Divide-by-zero, signed overflow and dividend < divisor have fully defined results.
- Used as the shared multi-cycle DIV/REM unit behind the integer execute stage.

---
 rtl/divider_pkg.sv | 19 +
 rtl/nr_div_step.sv | 23 ++
 rtl/signed_non_restoring_divider.sv | 129 ++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and helpers for the signed/unsigned non-restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        RESTORE,
        DONE
    } fsm_state_t;

    // Widest operand the negation helper can handle; callers cast in and out.
    localparam int MAX_WIDTH = 256;

    function automatic logic [MAX_WIDTH-1:0] negate_if(input logic [MAX_WIDTH-1:0] value,
                                                       input logic                 negate);
        return negate ? (~value + 1'b1) : value;
    endfunction

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring iteration: shift {rem_sign, remainder, quotient} left, add or subtract the divisor, set the quotient LSB.
module nr_div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH:0] acc_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [2*DATA_WIDTH:0] acc_o
);

    logic [DATA_WIDTH:0] shifted_rem;
    logic [DATA_WIDTH:0] divisor_ext;
    logic [DATA_WIDTH:0] new_rem;

    // Wrap-around in the shifted value is harmless: the add/subtract brings it back in range.
    always_comb begin
        shifted_rem = acc_i[2*DATA_WIDTH-1:DATA_WIDTH-1];
        divisor_ext = {1'b0, divisor_i};
        new_rem     = acc_i[2*DATA_WIDTH] ? (shifted_rem + divisor_ext)
                                          : (shifted_rem - divisor_ext);
        acc_o       = {new_rem, acc_i[DATA_WIDTH-2:0], ~new_rem[DATA_WIDTH]};
    end

endmodule

// File: rtl/signed_non_restoring_divider.sv
// Iterative non-restoring integer divider producing one quotient bit per cycle, signed or unsigned per operation.
module signed_non_restoring_divider
    import divider_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clk_en_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic                  signed_i,
    input  logic                  data_valid_i,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o,
    output logic                  divide_by_zero_o,
    output logic                  data_valid_o,
    output logic                  idle_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DATA_WIDTH - 1);

    typedef struct packed {
        logic                  rem_sign;
        logic [DATA_WIDTH-1:0] remainder;
        logic [DATA_WIDTH-1:0] quotient;
    } result_t;

    fsm_state_t            state;
    fsm_state_t            next_state;
    result_t               acc;
    result_t               acc_step;
    logic [DATA_WIDTH-1:0] divisor_mag;
    logic                  quot_neg;
    logic                  rem_neg;
    logic [CNT_W-1:0]      count;
    logic                  accept;

    logic                  dd_neg;
    logic                  dv_neg;
    logic [DATA_WIDTH-1:0] dd_mag;
    logic [DATA_WIDTH-1:0] dv_mag;
    logic [DATA_WIDTH-1:0] restored_rem;
    logic [DATA_WIDTH-1:0] final_quot;
    logic [DATA_WIDTH-1:0] final_rem;

    nr_div_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .acc_i    (acc),
        .divisor_i(divisor_mag),
        .acc_o    (acc_step)
    );

    // The iteration works on magnitudes only; signs are reapplied in RESTORE.
    always_comb begin
        dd_neg       = signed_i & dividend_i[DATA_WIDTH-1];
        dv_neg       = signed_i & divisor_i[DATA_WIDTH-1];
        dd_mag       = DATA_WIDTH'(negate_if(MAX_WIDTH'(dividend_i), dd_neg));
        dv_mag       = DATA_WIDTH'(negate_if(MAX_WIDTH'(divisor_i), dv_neg));
        restored_rem = acc.rem_sign ? (acc.remainder + divisor_mag) : acc.remainder;
        final_quot   = DATA_WIDTH'(negate_if(MAX_WIDTH'(acc.quotient), quot_neg));
        final_rem    = DATA_WIDTH'(negate_if(MAX_WIDTH'(restored_rem), rem_neg));
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        idle_o     = 1'b0;
        case (state)
            IDLE, DONE: begin
                idle_o = 1'b1;
                accept = data_valid_i;
                if (data_valid_i) begin
                    next_state = (divisor_i == '0) ? DONE : DIVIDE;
                end else begin
                    next_state = IDLE;
                end
            end
            DIVIDE: begin
                if (count == LAST_COUNT) begin
                    next_state = RESTORE;
                end
            end
            RESTORE: next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state            <= IDLE;
            acc              <= '0;
            divisor_mag      <= '0;
            quot_neg         <= 1'b0;
            rem_neg          <= 1'b0;
            count            <= '0;
            quotient_o       <= '0;
            remainder_o      <= '0;
            divide_by_zero_o <= 1'b0;
            data_valid_o     <= 1'b0;
        end else if (clk_en_i) begin
            state        <= next_state;
            data_valid_o <= (next_state == DONE);
            if (accept) begin
                acc         <= {1'b0, {DATA_WIDTH{1'b0}}, dd_mag};
                divisor_mag <= dv_mag;
                quot_neg    <= dd_neg ^ dv_neg;
                rem_neg     <= dd_neg;
                count       <= '0;
                // Divide by zero skips the iteration and publishes its fixed result immediately.
                if (divisor_i == '0) begin
                    quotient_o       <= '1;
                    remainder_o      <= dividend_i;
                    divide_by_zero_o <= 1'b1;
                end
            end else if (state == DIVIDE) begin
                acc   <= acc_step;
                count <= count + CNT_W'(1);
            end else if (state == RESTORE) begin
                quotient_o       <= final_quot;
                remainder_o      <= final_rem;
                divide_by_zero_o <= 1'b0;
            end
        end
    end

endmodule
